// File: rtl/de0_pkg.sv
// rtl/de0_pkg.sv - shared constants for the DE0 board shell
// Purpose: IO port map of the glue registers and the 7-segment lookup.
// Ports: none (package).
package de0_pkg;

  localparam logic [7:0] IO_LED    = 8'h00;
  localparam logic [7:0] IO_SW     = 8'h01;
  localparam logic [7:0] IO_HEX_LO = 8'h02;
  localparam logic [7:0] IO_HEX_HI = 8'h03;

  // Active-low segments {dp,g,f,e,d,c,b,a}; entry n sits at index n.
  // Bit 7 is 1 in every entry so the decimal point stays dark.
  localparam logic [15:0][7:0] SEG7_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/cpu8080_wb.sv
// rtl/cpu8080_wb.sv - interface shell of the 8080 Wishbone CPU wrapper
// Purpose: port-compatible stand-in for the existing CPU wrapper; it holds the
//   bus idle so the shell elaborates on its own. The real wrapper file
//   replaces this one in the full build.
// Ports: clk, ce, rst in; adr_o/dat_o/cyc_o/stb_o/we_o/io_o out (master side);
//   dat_i/ack_i in (slave response).
module cpu8080_wb (
  input  logic        clk,
  input  logic        ce,
  input  logic        rst,
  output logic [15:0] adr_o,
  output logic [7:0]  dat_o,
  input  logic [7:0]  dat_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic        io_o,
  input  logic        ack_i
);

  logic unused_cpu_inputs;

  assign adr_o = 16'h0000;
  assign dat_o = 8'h00;
  assign cyc_o = 1'b0;
  assign stb_o = 1'b0;
  assign we_o  = 1'b0;
  assign io_o  = 1'b0;

  assign unused_cpu_inputs = ^{clk, ce, rst, dat_i, ack_i};

endmodule

// File: rtl/de0_board_top_seg7_decoder.sv
// rtl/de0_board_top_seg7_decoder.sv - hex nibble to active-low 7-segment pattern
// Purpose: combinational lookup of one digit, decimal point off.
// Ports: digit (4-bit value in), seg (8-bit active-low segments out).
module seg7_decoder
  import de0_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  assign seg = SEG7_LUT[digit];

endmodule

// File: rtl/de0_board_top.sv
// rtl/de0_board_top.sv - Terasic DE0 shell: reset/ce conditioning and 8080 glue
// Purpose: synchronised reset from button[0], turbo/slow CPU clock enable,
//   on-chip RAM, LED and 7-segment IO registers, tie-offs for idle peripherals.
// Ports: de0_clock_50 clock; de0_button[0] active-low reset; de0_sw[0] turbo;
//   de0_hex0..3 / de0_led displays; all remaining board pins parked safe.
module de0_board_top
  import de0_pkg::*;
#(
  parameter int    RAM_AW   = 13,
  parameter string RAM_INIT = "",
  parameter int    SLOW_DIV = 20
) (
  input  logic        de0_clock_50,
  input  logic [2:0]  de0_button,
  input  logic        de0_clock_50_2,
  input  logic [9:0]  de0_sw,
  output logic [7:0]  de0_hex0,
  output logic [7:0]  de0_hex1,
  output logic [7:0]  de0_hex2,
  output logic [7:0]  de0_hex3,
  output logic [9:0]  de0_led,
  output logic        de0_uart_txd,
  output logic        de0_uart_cts,
  input  logic        de0_uart_rxd,
  input  logic        de0_uart_rts,
  inout  wire  [15:0] de0_dram_dq,
  output logic [12:0] de0_dram_addr,
  output logic [1:0]  de0_dram_ba,
  output logic        de0_dram_ldqm,
  output logic        de0_dram_udqm,
  output logic        de0_dram_we_n,
  output logic        de0_dram_cas_n,
  output logic        de0_dram_ras_n,
  output logic        de0_dram_cs_n,
  output logic        de0_dram_clk,
  output logic        de0_dram_cke,
  inout  wire  [15:0] de0_fl_dq,
  output logic [21:0] de0_fl_addr,
  output logic        de0_fl_we_n,
  output logic        de0_fl_rst_n,
  output logic        de0_fl_oe_n,
  output logic        de0_fl_ce_n,
  output logic        de0_fl_wp_n,
  output logic        de0_fl_byte_n,
  input  logic        de0_fl_rb,
  output logic        de0_lcd_blig,
  output logic        de0_lcd_rw,
  output logic        de0_lcd_en,
  output logic        de0_lcd_rs,
  inout  wire  [7:0]  de0_lcd_data,
  inout  wire         de0_sd_mosi,
  inout  wire         de0_sd_miso,
  inout  wire         de0_sd_cmd,
  output logic        de0_sd_clk,
  input  logic        de0_sd_wp_n,
  inout  wire         de0_ps2_kbdat,
  inout  wire         de0_ps2_kbclk,
  inout  wire         de0_ps2_msdat,
  inout  wire         de0_ps2_msclk,
  output logic        de0_vga_hs,
  output logic        de0_vga_vs,
  output logic [3:0]  de0_vga_r,
  output logic [3:0]  de0_vga_g,
  output logic [3:0]  de0_vga_b,
  input  logic [1:0]  de0_gpio0_clkin,
  input  logic [1:0]  de0_gpio1_clkin,
  output logic [1:0]  de0_gpio0_clkout,
  output logic [1:0]  de0_gpio1_clkout,
  inout  wire  [31:0] de0_gpio0_d,
  inout  wire  [31:0] de0_gpio1_d
);

  localparam int DIV_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

  logic clk;
  logic rst_raw;
  logic [1:0] rst_sync;
  logic rst;
  logic [1:0] sw0_sync;
  logic turbo;
  logic turbo_act;
  logic [DIV_W-1:0] div_cnt;
  logic div_wrap;
  logic ce;
  logic [23:0] hb_cnt;
  logic heartbeat;

  logic [15:0] cpu_adr;
  logic [7:0]  cpu_dat_o;
  logic [7:0]  cpu_dat_i;
  logic        cpu_cyc, cpu_stb, cpu_we, cpu_io, cpu_ack;

  logic        cyc_stb;
  logic        in_ram;
  logic [7:0]  io_rd_data;
  logic [7:0]  rd_q;
  logic        rd_ram;
  logic [7:0]  ram_q;
  logic [7:0]  mem [2**RAM_AW];
  logic [7:0]  led_reg;
  logic [15:0] hex_reg;

  assign clk     = de0_clock_50;
  assign rst_raw = ~de0_button[0];

  // Preset on the raw button, shift zeros in once it is released.
  always_ff @(posedge clk or posedge rst_raw) begin
    if (rst_raw) rst_sync <= 2'b11;
    else         rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst = rst_sync[1];

  always_ff @(posedge clk) begin
    sw0_sync <= {sw0_sync[0], de0_sw[0]};
  end
  assign turbo = sw0_sync[1];

  // The divider runs in both modes; the mode is only sampled at the wrap,
  // so switching never shortens or doubles a slow-mode period.
  assign div_wrap = (div_cnt == DIV_W'(SLOW_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      turbo_act <= 1'b0;
    end else if (div_wrap) begin
      div_cnt   <= '0;
      turbo_act <= turbo;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end
  assign ce = ~rst & (turbo_act | div_wrap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
      if (&hb_cnt) heartbeat <= ~heartbeat;
    end
  end

  cpu8080_wb u_cpu (
    .clk   (clk),
    .ce    (ce),
    .rst   (rst),
    .adr_o (cpu_adr),
    .dat_o (cpu_dat_o),
    .dat_i (cpu_dat_i),
    .cyc_o (cpu_cyc),
    .stb_o (cpu_stb),
    .we_o  (cpu_we),
    .io_o  (cpu_io),
    .ack_i (cpu_ack)
  );

  assign cyc_stb = cpu_cyc & cpu_stb;
  assign in_ram  = (cpu_adr[15:RAM_AW] == '0);

  always_comb begin
    io_rd_data = 8'hFF;
    if (cpu_io) begin
      case (cpu_adr[7:0])
        IO_LED:  io_rd_data = led_reg;
        IO_SW:   io_rd_data = de0_sw[7:0];
        default: io_rd_data = 8'hFF;
      endcase
    end
  end

  // RAM is read every clock; the strobe cycle's read lands in ram_q exactly
  // when ack rises. Writes commit on the ack clock only.
  always_ff @(posedge clk) begin
    if (cyc_stb & cpu_we & cpu_ack & ~cpu_io & in_ram)
      mem[cpu_adr[RAM_AW-1:0]] <= cpu_dat_o;
    ram_q <= mem[cpu_adr[RAM_AW-1:0]];
  end

  // ack toggles against itself, so a held strobe is acked every second clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_ack <= 1'b0;
      rd_q    <= 8'hFF;
      rd_ram  <= 1'b0;
      led_reg <= 8'h00;
      hex_reg <= 16'h0000;
    end else begin
      cpu_ack <= cyc_stb & ~cpu_ack;
      if (cyc_stb & ~cpu_ack) begin
        rd_ram <= ~cpu_io & in_ram;
        rd_q   <= io_rd_data;
      end
      if (cyc_stb & cpu_we & cpu_ack & cpu_io) begin
        case (cpu_adr[7:0])
          IO_LED:    led_reg       <= cpu_dat_o;
          IO_HEX_LO: hex_reg[7:0]  <= cpu_dat_o;
          IO_HEX_HI: hex_reg[15:8] <= cpu_dat_o;
          default:   ;
        endcase
      end
    end
  end
  assign cpu_dat_i = rd_ram ? ram_q : rd_q;

  assign de0_led = {heartbeat, turbo, led_reg};

  seg7_decoder u_hex0 (.digit(hex_reg[3:0]),   .seg(de0_hex0));
  seg7_decoder u_hex1 (.digit(hex_reg[7:4]),   .seg(de0_hex1));
  seg7_decoder u_hex2 (.digit(hex_reg[11:8]),  .seg(de0_hex2));
  seg7_decoder u_hex3 (.digit(hex_reg[15:12]), .seg(de0_hex3));

  assign de0_uart_txd     = 1'b1;
  assign de0_uart_cts     = 1'b0;
  assign de0_dram_dq      = 'z;
  assign de0_dram_addr    = '0;
  assign de0_dram_ba      = '0;
  assign de0_dram_ldqm    = 1'b1;
  assign de0_dram_udqm    = 1'b1;
  assign de0_dram_we_n    = 1'b1;
  assign de0_dram_cas_n   = 1'b1;
  assign de0_dram_ras_n   = 1'b1;
  assign de0_dram_cs_n    = 1'b1;
  assign de0_dram_clk     = 1'b0;
  assign de0_dram_cke     = 1'b0;
  assign de0_fl_dq        = 'z;
  assign de0_fl_addr      = '0;
  assign de0_fl_we_n      = 1'b1;
  assign de0_fl_rst_n     = 1'b1;
  assign de0_fl_oe_n      = 1'b1;
  assign de0_fl_ce_n      = 1'b1;
  assign de0_fl_wp_n      = 1'b1;
  assign de0_fl_byte_n    = 1'b1;
  assign de0_lcd_blig     = 1'b0;
  assign de0_lcd_rw       = 1'b1;
  assign de0_lcd_en       = 1'b0;
  assign de0_lcd_rs       = 1'b0;
  assign de0_lcd_data     = 'z;
  assign de0_sd_mosi      = 1'bz;
  assign de0_sd_miso      = 1'bz;
  assign de0_sd_cmd       = 1'bz;
  assign de0_sd_clk       = 1'b0;
  assign de0_ps2_kbdat    = 1'bz;
  assign de0_ps2_kbclk    = 1'bz;
  assign de0_ps2_msdat    = 1'bz;
  assign de0_ps2_msclk    = 1'bz;
  assign de0_vga_hs       = 1'b1;
  assign de0_vga_vs       = 1'b1;
  assign de0_vga_r        = '0;
  assign de0_vga_g        = '0;
  assign de0_vga_b        = '0;
  assign de0_gpio0_clkout = '0;
  assign de0_gpio1_clkout = '0;
  assign de0_gpio0_d      = 'z;
  assign de0_gpio1_d      = 'z;

  // RAM_INIT is consumed by the device image flow, not by this logic.
  logic unused_top;
  assign unused_top = ^{de0_button[2:1], de0_clock_50_2, de0_sw[9:8],
                        de0_uart_rxd, de0_uart_rts, de0_fl_rb, de0_sd_wp_n,
                        de0_gpio0_clkin, de0_gpio1_clkin, (RAM_INIT == "")};

endmodule

// File: tb/tb_de0_board_top.sv
// tb/tb_de0_board_top.sv - self-checking bench for the DE0 board shell
module tb_de0_board_top;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic [2:0] button = 3'b000;
  logic       clk2 = 1'b0;
  logic [9:0] sw = 10'h000;
  logic       uart_rxd = 1'b1, uart_rts = 1'b0, fl_rb = 1'b1, sd_wp_n = 1'b1;
  logic [1:0] g0_clkin = 2'b00, g1_clkin = 2'b00;

  wire [7:0]  hex0, hex1, hex2, hex3;
  wire [9:0]  led;
  wire        uart_txd, uart_cts;
  wire [15:0] dram_dq;
  wire [12:0] dram_addr;
  wire [1:0]  dram_ba;
  wire        dram_ldqm, dram_udqm, dram_we_n, dram_cas_n, dram_ras_n, dram_cs_n, dram_clk, dram_cke;
  wire [15:0] fl_dq;
  wire [21:0] fl_addr;
  wire        fl_we_n, fl_rst_n, fl_oe_n, fl_ce_n, fl_wp_n, fl_byte_n;
  wire        lcd_blig, lcd_rw, lcd_en, lcd_rs;
  wire [7:0]  lcd_data;
  wire        sd_mosi, sd_miso, sd_cmd, sd_clk;
  wire        kbdat, kbclk, msdat, msclk;
  wire        vga_hs, vga_vs;
  wire [3:0]  vga_r, vga_g, vga_b;
  wire [1:0]  g0_clkout, g1_clkout;
  wire [31:0] g0_d, g1_d;

  de0_board_top dut (
    .de0_clock_50(clk), .de0_button(button), .de0_clock_50_2(clk2), .de0_sw(sw),
    .de0_hex0(hex0), .de0_hex1(hex1), .de0_hex2(hex2), .de0_hex3(hex3), .de0_led(led),
    .de0_uart_txd(uart_txd), .de0_uart_cts(uart_cts), .de0_uart_rxd(uart_rxd), .de0_uart_rts(uart_rts),
    .de0_dram_dq(dram_dq), .de0_dram_addr(dram_addr), .de0_dram_ba(dram_ba),
    .de0_dram_ldqm(dram_ldqm), .de0_dram_udqm(dram_udqm), .de0_dram_we_n(dram_we_n),
    .de0_dram_cas_n(dram_cas_n), .de0_dram_ras_n(dram_ras_n), .de0_dram_cs_n(dram_cs_n),
    .de0_dram_clk(dram_clk), .de0_dram_cke(dram_cke),
    .de0_fl_dq(fl_dq), .de0_fl_addr(fl_addr), .de0_fl_we_n(fl_we_n), .de0_fl_rst_n(fl_rst_n),
    .de0_fl_oe_n(fl_oe_n), .de0_fl_ce_n(fl_ce_n), .de0_fl_wp_n(fl_wp_n), .de0_fl_byte_n(fl_byte_n),
    .de0_fl_rb(fl_rb),
    .de0_lcd_blig(lcd_blig), .de0_lcd_rw(lcd_rw), .de0_lcd_en(lcd_en), .de0_lcd_rs(lcd_rs),
    .de0_lcd_data(lcd_data),
    .de0_sd_mosi(sd_mosi), .de0_sd_miso(sd_miso), .de0_sd_cmd(sd_cmd), .de0_sd_clk(sd_clk),
    .de0_sd_wp_n(sd_wp_n),
    .de0_ps2_kbdat(kbdat), .de0_ps2_kbclk(kbclk), .de0_ps2_msdat(msdat), .de0_ps2_msclk(msclk),
    .de0_vga_hs(vga_hs), .de0_vga_vs(vga_vs), .de0_vga_r(vga_r), .de0_vga_g(vga_g), .de0_vga_b(vga_b),
    .de0_gpio0_clkin(g0_clkin), .de0_gpio1_clkin(g1_clkin),
    .de0_gpio0_clkout(g0_clkout), .de0_gpio1_clkout(g1_clkout),
    .de0_gpio0_d(g0_d), .de0_gpio1_d(g1_d)
  );

  int checks = 0;
  int errors = 0;

  // Bus master side, driven onto the shell's CPU bus in place of the CPU.
  logic [15:0] b_adr = 16'h0000;
  logic [7:0]  b_dat = 8'h00;
  logic        b_cyc = 1'b0, b_stb = 1'b0, b_we = 1'b0, b_io = 1'b0;

  // Reference model state.
  logic [7:0]  ram_m [int];
  int          written_q [$];
  logic [7:0]  led_m = 8'h00;
  logic [15:0] hex_m = 16'h0000;

  task automatic drive_bus();
    force dut.cpu_adr   = b_adr;
    force dut.cpu_dat_o = b_dat;
    force dut.cpu_cyc   = b_cyc;
    force dut.cpu_stb   = b_stb;
    force dut.cpu_we    = b_we;
    force dut.cpu_io    = b_io;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  task automatic check_display(input string tag);
    chk({tag, "_led"},  {24'h0, led[7:0]}, {24'h0, led_m});
    chk({tag, "_hex0"}, {24'h0, hex0}, {24'h0, seg_of(hex_m[3:0])});
    chk({tag, "_hex1"}, {24'h0, hex1}, {24'h0, seg_of(hex_m[7:4])});
    chk({tag, "_hex2"}, {24'h0, hex2}, {24'h0, seg_of(hex_m[11:8])});
    chk({tag, "_hex3"}, {24'h0, hex3}, {24'h0, seg_of(hex_m[15:12])});
  endtask

  task automatic wb(input bit io, input bit we, input logic [15:0] adr,
                    input logic [7:0] dat, output logic [7:0] rd);
    bit got = 1'b0;
    rd = 8'h00;
    @(negedge clk);
    b_adr = adr; b_dat = dat; b_io = io; b_we = we; b_cyc = 1'b1; b_stb = 1'b1;
    drive_bus();
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (dut.cpu_ack === 1'b1) begin
        got = 1'b1;
        rd  = dut.cpu_dat_i;
      end
    end
    if (!got) chk("wb_ack_timeout", 32'(got), 32'd1);
    @(negedge clk);
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
    drive_bus();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int pulses [$];
    int cnt;
    drive_bus();

    // Reset held from time zero.
    repeat (10) @(negedge clk);
    chk("rst_led_low", {24'h0, led[7:0]}, 32'h00);
    chk("rst_heartbeat", {31'h0, led[9]}, 32'h0);
    chk("rst_hex0", {24'h0, hex0}, 32'hC0);
    chk("rst_hex1", {24'h0, hex1}, 32'hC0);
    chk("rst_hex2", {24'h0, hex2}, 32'hC0);
    chk("rst_hex3", {24'h0, hex3}, 32'hC0);
    chk("tie_dram_cs_n", {31'h0, dram_cs_n}, 32'h1);
    chk("tie_fl_ce_n", {31'h0, fl_ce_n}, 32'h1);
    chk("tie_uart_txd", {31'h0, uart_txd}, 32'h1);
    chk("tie_dram_cke", {31'h0, dram_cke}, 32'h0);
    chk("tie_vga", {20'h0, vga_hs, vga_vs, vga_r, vga_g, vga_b}, {20'h0, 2'b11, 12'h000});
    chk("tie_lcd_rw", {31'h0, lcd_rw}, 32'h1);
    chk("rst_internal", {31'h0, dut.rst}, 32'h1);

    button = 3'b111;
    @(posedge clk); #1;
    chk("rst_after_1_edge", {31'h0, dut.rst}, 32'h1);
    @(posedge clk); #1;
    chk("rst_after_2_edges", {31'h0, dut.rst}, 32'h0);

    // Turbo: enable every clock once the mode has been picked up.
    @(negedge clk); sw = 10'h001;
    repeat (30) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dut.ce === 1'b1) cnt++;
    end
    chk("ce_turbo_count", cnt, 40);
    chk("led8_turbo", {31'h0, led[8]}, 32'h1);

    // Slow: one pulse per divisor period.
    sw = 10'h000;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dut.ce === 1'b1) pulses.push_back(i);
    end
    chk("ce_slow_count", pulses.size(), 100 / 20);
    for (int i = 1; i < pulses.size(); i++)
      chk("ce_slow_gap", pulses[i] - pulses[i-1], 20);
    chk("led8_slow", {31'h0, led[8]}, 32'h0);

    sw = 10'h001;
    repeat (30) @(negedge clk);

    // Directed RAM and IO accesses.
    wb(0, 1, 16'h0100, 8'hA5, rd);
    ram_m[16'h0100] = 8'hA5; written_q.push_back(16'h0100);
    wb(0, 0, 16'h0100, 8'h00, rd);
    chk("ram_rd_0100", {24'h0, rd}, 32'hA5);
    wb(0, 0, 16'h8000, 8'h00, rd);
    chk("mem_rd_8000", {24'h0, rd}, 32'hFF);
    wb(1, 1, 16'h0000, 8'h3C, rd);
    @(negedge clk);
    chk("out00_led", {24'h0, led[7:0]}, 32'h3C);
    led_m = 8'h3C;
    wb(1, 1, 16'h0202, 8'h34, rd);
    wb(1, 1, 16'h0303, 8'h12, rd);
    hex_m = 16'h1234;
    @(negedge clk);
    chk("hex_digits", {hex3, hex2, hex1, hex0}, 32'hF9A4B099);
    sw = 10'h0F5;
    repeat (3) @(negedge clk);
    wb(1, 0, 16'h0101, 8'h00, rd);
    chk("in01_sw", {24'h0, rd}, 32'hF5);
    wb(1, 0, 16'h0707, 8'h00, rd);
    chk("in07_ff", {24'h0, rd}, 32'hFF);

    // Randomised traffic against the model.
    for (int n = 0; n < 80; n++) begin
      int op;
      logic [15:0] a;
      logic [7:0]  d, p;
      op = $urandom_range(0, 4);
      d  = 8'($urandom);
      case (op)
        0: begin
          if ($urandom_range(0, 7) == 0) a = 16'h2000 + 16'($urandom_range(0, 16'hDFFF));
          else                           a = 16'($urandom_range(0, 16'h1FFF));
          wb(0, 1, a, d, rd);
          if (a < 16'h2000) begin
            if (!ram_m.exists(int'(a))) written_q.push_back(int'(a));
            ram_m[int'(a)] = d;
          end
        end
        1: begin
          if (written_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            a = 16'(written_q[$urandom_range(0, written_q.size() - 1)]);
            wb(0, 0, a, 8'h00, rd);
            chk("rand_ram_rd", {16'h0, a[7:0], rd}, {16'h0, a[7:0], ram_m[int'(a)]});
          end else begin
            a = 16'h2000 + 16'($urandom_range(0, 16'hDFFF));
            wb(0, 0, a, 8'h00, rd);
            chk("rand_hi_rd", {24'h0, rd}, 32'hFF);
          end
        end
        2: begin
          p = 8'($urandom_range(0, 7));
          wb(1, 1, {p, p}, d, rd);
          if (p == 8'h00) led_m = d;
          if (p == 8'h02) hex_m[7:0] = d;
          if (p == 8'h03) hex_m[15:8] = d;
          @(negedge clk);
          check_display("rand_out");
        end
        3: begin
          p = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
          wb(1, 0, {p, p}, 8'h00, rd);
          chk("rand_in", {16'h0, p, rd},
              {16'h0, p, (p == 8'h00) ? led_m : (p == 8'h01) ? sw[7:0] : 8'hFF});
        end
        default: begin
          sw = {9'($urandom), 1'b1};
          repeat (3) @(negedge clk);
        end
      endcase
    end
    chk("turbo_led8_end", {31'h0, led[8]}, 32'h1);

    // Reset during an OUT 0x00 cycle.
    wb(1, 1, 16'h0000, 8'h5A, rd);
    led_m = 8'h5A;
    @(negedge clk);
    chk("pre_reset_led", {24'h0, led[7:0]}, 32'h5A);
    b_adr = 16'h0000; b_dat = 8'h77; b_io = 1'b1; b_we = 1'b1; b_cyc = 1'b1; b_stb = 1'b1;
    drive_bus();
    #3 button = 3'b110;
    #1;
    chk("async_rst_led", {24'h0, led[7:0]}, 32'h00);
    chk("async_rst_hex", {hex3, hex2, hex1, hex0}, 32'hC0C0C0C0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_ack", {31'h0, dut.cpu_ack}, 32'h0);
    end
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
    drive_bus();
    button = 3'b111;
    led_m = 8'h00; hex_m = 16'h0000;
    repeat (4) @(negedge clk);
    chk("post_rst_released", {31'h0, dut.rst}, 32'h0);
    check_display("post_rst");
    wb(1, 0, 16'h0000, 8'h00, rd);
    chk("post_rst_in00", {24'h0, rd}, 32'h00);
    chk("heartbeat_low", {31'h0, led[9]}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
